// File: rtl/hazard_operand_loader_pkg.sv
// Shared constants and FSM encoding for the hazard detector operand loader.
package hazard_pkg;

  localparam int DATA_W = 8;
  localparam int LANES  = 8;
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_operand_loader_if.sv
// Byte-in / result-out handshake bundle between the loader and its neighbours.
interface hazard_operand_loader_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_ready;

  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_data
  );

  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_data
  );
endinterface

// File: rtl/hazard_operand_loader_lane_bank.sv
// Eight operand registers written one at a time by index; sync clear zeroes them all.
module operand_lane_bank
  import hazard_pkg::*;
#(
  parameter int DATA_W = hazard_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_lanes [LANES]
);

  logic [DATA_W-1:0] r_lanes [LANES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) r_lanes[i] <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < LANES; i++) r_lanes[i] <= '0;
    end else if (i_we) begin
      r_lanes[i_widx] <= i_wdata;
    end
  end

  assign o_lanes = r_lanes;

endmodule

// File: rtl/hazard_operand_loader.sv
// Loads an 8-byte snapshot for the hazard detector, waits for it to settle, then offers the result.
module hazard_operand_loader
  import hazard_pkg::*;
#(
  parameter int DATA_W     = hazard_pkg::DATA_W,
  parameter int SETTLE_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  hazard_operand_loader_if.slave  bus,
  output logic [DATA_W-1:0]       a0,
  output logic [DATA_W-1:0]       a1,
  output logic [DATA_W-1:0]       a2,
  output logic [DATA_W-1:0]       a3,
  output logic [DATA_W-1:0]       a4,
  output logic [DATA_W-1:0]       a5,
  output logic [DATA_W-1:0]       a6,
  output logic [DATA_W-1:0]       a7,
  output logic                    snap_valid,
  input  logic [DATA_W-1:0]       hz_result
);

  state_t            r_state;
  state_t            w_next_state;
  logic [IDX_W-1:0]  r_idx;
  logic [2:0]        r_settle_cnt;
  logic              r_res_valid;
  logic [DATA_W-1:0] r_res_data;

  logic              w_in_ready;
  logic              w_snap_valid;
  logic              w_accept;
  logic              w_take;
  logic              w_last_lane;
  logic [DATA_W-1:0] w_lanes [LANES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = LOAD;
    end else begin
      case (r_state)
        LOAD:    if (w_accept && w_last_lane) w_next_state = SETTLE;
        SETTLE:  if (r_settle_cnt == 3'd0)    w_next_state = HOLD;
        HOLD:    if (w_take)                  w_next_state = LOAD;
        default: w_next_state = LOAD;
      endcase
    end
  end

  // clear masks both handshakes so an abort never consumes a byte or a result.
  always_comb begin
    w_in_ready   = (r_state == LOAD);
    w_snap_valid = (r_state != LOAD);
    w_accept     = bus.in_valid && w_in_ready && !clear;
    w_take       = r_res_valid && bus.res_ready && !clear;
    w_last_lane  = (r_idx == IDX_W'(LANES - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx        <= '0;
      r_settle_cnt <= '0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
    end else if (clear) begin
      r_idx       <= '0;
      r_res_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_idx <= r_idx + 1'b1;
        if (w_last_lane) r_settle_cnt <= 3'(SETTLE_CYC - 1);
      end
      if (r_state == SETTLE) begin
        if (r_settle_cnt == 3'd0) begin
          r_res_data  <= hz_result;
          r_res_valid <= 1'b1;
        end else begin
          r_settle_cnt <= r_settle_cnt - 1'b1;
        end
      end
      if (w_take) r_res_valid <= 1'b0;
    end
  end

  operand_lane_bank #(
    .DATA_W (DATA_W)
  ) u_lane_bank (
    .clk     (clk),
    .rst     (rst),
    .i_clear (clear),
    .i_we    (w_accept),
    .i_widx  (r_idx),
    .i_wdata (bus.in_data),
    .o_lanes (w_lanes)
  );

  assign a0 = w_lanes[0];
  assign a1 = w_lanes[1];
  assign a2 = w_lanes[2];
  assign a3 = w_lanes[3];
  assign a4 = w_lanes[4];
  assign a5 = w_lanes[5];
  assign a6 = w_lanes[6];
  assign a7 = w_lanes[7];

  assign snap_valid    = w_snap_valid;
  assign bus.in_ready  = w_in_ready;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;

endmodule

// File: tb/tb_hazard_operand_loader.sv
// Directed bench for the operand loader with a stub detector computing a0 ^ a7.
module tb_hazard_operand_loader;

  logic       clk;
  logic       rst;
  logic       clear;
  logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7;
  logic       snap_valid;
  logic [7:0] hz_result;
  logic [63:0] lanesFlat;

  int testsRun  = 0;
  int failCount = 0;

  hazard_operand_loader_if #(.DATA_W(8)) bus ();

  hazard_operand_loader #(
    .DATA_W     (8),
    .SETTLE_CYC (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .bus        (bus),
    .a0         (a0),
    .a1         (a1),
    .a2         (a2),
    .a3         (a3),
    .a4         (a4),
    .a5         (a5),
    .a6         (a6),
    .a7         (a7),
    .snap_valid (snap_valid),
    .hz_result  (hz_result)
  );

  assign hz_result = a0 ^ a7;
  assign lanesFlat = {a0, a1, a2, a3, a4, a5, a6, a7};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers one byte for a single clock; caller has checked in_ready.
  task automatic applyStimulus(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic waitResult(input string tag, input logic [7:0] expData);
    int cycles = 0;
    while (bus.res_valid !== 1'b1 && cycles < 10) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, "_valid"}, 64'(bus.res_valid), 64'd1);
    checkOutput({tag, "_data"},  64'(bus.res_data),  64'(expData));
  endtask

  task automatic takeResult(input string tag);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    checkOutput({tag, "_taken"}, 64'(bus.res_valid), 64'd0);
    checkOutput({tag, "_ready"}, 64'(bus.in_ready),  64'd1);
  endtask

  initial begin
    logic [7:0] nomBytes [8];
    logic [7:0] clrBytes [8];
    logic [7:0] rldBytes [8];
    nomBytes = '{8'hca, 8'h93, 8'h6b, 8'hd1, 8'h96, 8'hca, 8'h7e, 8'h6f};
    clrBytes = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h5a};
    rldBytes = '{8'h0f, 8'h1e, 8'h2d, 8'h3c, 8'h4b, 8'h5a, 8'h69, 8'hf0};

    rst           = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.res_ready = 1'b0;

    // 1: asynchronous reset mid-cycle
    #3 rst = 1'b1;
    #1;
    checkOutput("rst_lanes",      lanesFlat,              64'h0);
    checkOutput("rst_res_valid",  64'(bus.res_valid),     64'd0);
    checkOutput("rst_res_data",   64'(bus.res_data),      64'd0);
    checkOutput("rst_snap_valid", 64'(snap_valid),        64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready",   64'(bus.in_ready),      64'd1);

    // 2: nominal back-to-back stream
    for (int i = 0; i < 8; i++) applyStimulus(nomBytes[i]);
    checkOutput("nom_lanes",      lanesFlat,              64'hca936bd196ca7e6f);
    checkOutput("nom_snap_valid", 64'(snap_valid),        64'd1);
    checkOutput("nom_in_ready",   64'(bus.in_ready),      64'd0);
    checkOutput("nom_valid_n0",   64'(bus.res_valid),     64'd0);
    @(negedge clk);
    checkOutput("nom_valid_n1",   64'(bus.res_valid),     64'd0);
    @(negedge clk);
    checkOutput("nom_valid_n2",   64'(bus.res_valid),     64'd1);
    checkOutput("nom_res_data",   64'(bus.res_data),      64'ha5);

    // 3: backpressure with a byte offered throughout
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hee;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_res_data", 64'(bus.res_data), 64'ha5);
      checkOutput("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    checkOutput("bp_lanes", lanesFlat, 64'hca936bd196ca7e6f);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    checkOutput("bp_taken",      64'(bus.res_valid), 64'd0);
    checkOutput("bp_ready_next", 64'(bus.in_ready),  64'd1);
    checkOutput("bp_no_consume", 64'(a0),            64'hca);
    checkOutput("bp_snap_low",   64'(snap_valid),    64'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);

    // 4: gapped input
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'(i + 1));
      bus.in_data = 8'hff;
      @(negedge clk);
    end
    checkOutput("gap_lanes", lanesFlat, 64'h0102030405060708);
    waitResult("gap", 8'h09);
    takeResult("gap");

    // 5: clear after a partial snapshot, then a clean reload
    for (int i = 0; i < 5; i++) applyStimulus(8'(8'h11 + i));
    checkOutput("clr_partial", 64'(a4), 64'h15);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkOutput("clr_lanes",    lanesFlat,          64'h0);
    checkOutput("clr_snap",     64'(snap_valid),    64'd0);
    checkOutput("clr_in_ready", 64'(bus.in_ready),  64'd1);
    checkOutput("clr_res_keep", 64'(bus.res_data),  64'h09);
    for (int i = 0; i < 8; i++) applyStimulus(clrBytes[i]);
    checkOutput("clr_reload", lanesFlat, 64'h212223242526275a);
    waitResult("clr", 8'h7b);
    takeResult("clr");
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    @(negedge clk);
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("clr_drop", lanesFlat, 64'h0);
    applyStimulus(8'h44);
    checkOutput("clr_idx0", lanesFlat, 64'h4400000000000000);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;

    // 6: reset during SETTLE discards the result
    for (int i = 0; i < 8; i++) applyStimulus(8'(i + 1));
    checkOutput("rs_settle_snap", 64'(snap_valid), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("rs_lanes", lanesFlat,          64'h0);
    checkOutput("rs_snap",  64'(snap_valid),    64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rs_no_valid", 64'(bus.res_valid), 64'd0);
      checkOutput("rs_in_ready", 64'(bus.in_ready),  64'd1);
    end
    bus.res_ready = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(rldBytes[i]);
    checkOutput("rs_reload", lanesFlat, 64'h0f1e2d3c4b5a69f0);
    waitResult("rs", 8'hff);
    takeResult("rs");

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
